// File: rtl/saa_pkg.sv
// saa_pkg: shared types and period arithmetic for the SAA tone bank
package saa_pkg;
    localparam int CFG_FREQ_W = 16;
    localparam int CFG_OCT_W = 4;

    typedef enum logic {IDLE, SWEEP} sweep_state_t;

    typedef struct packed {
        logic [CFG_FREQ_W-1:0] freq;
        logic [CFG_OCT_W-1:0]  oct;
    } chan_cfg_t;

    function automatic int cnt_width(input int freq_w, input int oct_w);
        return freq_w + 1 + (1 << oct_w);
    endfunction

    // Reload value; a channel toggles every period+1 ticks
    function automatic logic [31:0] period(input logic [31:0] f, input logic [31:0] o,
                                           input int freq_w, input int oct_w);
        return ((((32'd1 << (freq_w + 1)) - 32'd1 - f) << ((32'd1 << oct_w) - o)) - 32'd1);
    endfunction
endpackage

// File: rtl/saa_tone_bank.sv
// saa_tone_bank: time-multiplexed square-wave tone channels with staged frequency updates
module saa_tone_bank
    import saa_pkg::*;
#(
    parameter int CHANNELS = 6,
    parameter int FREQ_W = 8,
    parameter int OCT_W = 3,
    localparam int IDX_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_sys,
    input  logic                rst_n,
    input  logic                ce,
    input  logic                sync,
    input  logic                wr,
    input  logic [IDX_W-1:0]    wr_ch,
    input  logic [FREQ_W-1:0]   wr_freq,
    input  logic [OCT_W-1:0]    wr_oct,
    output logic [CHANNELS-1:0] tone,
    output logic [CHANNELS-1:0] pulse,
    output logic                busy,
    output logic                overrun
);
    localparam int CNT_W = cnt_width(FREQ_W, OCT_W);
    localparam logic [CNT_W-1:0] RST_CNT = CNT_W'(period(32'd0, 32'd0, FREQ_W, OCT_W));

    sweep_state_t     state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [CNT_W-1:0] count [CHANNELS];
    logic [CNT_W-1:0] reload [CHANNELS];
    chan_cfg_t        staged [CHANNELS];
    chan_cfg_t        staged_nxt [CHANNELS];
    logic [CNT_W-1:0] cur;
    logic             last;

    assign busy = state == SWEEP;
    assign cur = count[idx];
    assign last = idx == IDX_W'(CHANNELS - 1);

    // Incoming writes bypass into the reload value of the same cycle
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            staged_nxt[c] = staged[c];
            if (wr && wr_ch == IDX_W'(c)) begin
                staged_nxt[c].freq = CFG_FREQ_W'(wr_freq);
                staged_nxt[c].oct = CFG_OCT_W'(wr_oct);
            end
            reload[c] = CNT_W'(period(32'(staged_nxt[c].freq), 32'(staged_nxt[c].oct), FREQ_W, OCT_W));
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt = '0;
        if (sync)
            state_nxt = IDLE;
        else if (state == IDLE)
            state_nxt = ce ? SWEEP : IDLE;
        else begin
            state_nxt = last ? IDLE : SWEEP;
            idx_nxt = last ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx <= '0;
        end else begin
            state <= state_nxt;
            idx <= idx_nxt;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            tone <= '0;
            pulse <= '0;
            overrun <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                count[c] <= RST_CNT;
                staged[c] <= '0;
            end
        end else begin
            overrun <= overrun | (ce & busy);
            pulse <= '0;
            for (int c = 0; c < CHANNELS; c++)
                staged[c] <= staged_nxt[c];
            if (sync) begin
                tone <= '0;
                for (int c = 0; c < CHANNELS; c++)
                    count[c] <= reload[c];
            end else if (busy) begin
                if (cur == '0) begin
                    count[idx] <= reload[idx];
                    tone[idx] <= ~tone[idx];
                    pulse[idx] <= 1'b1;
                end else
                    count[idx] <= cur - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_saa_tone_bank.sv
// tb_saa_tone_bank: tick-level model of the tone bank checked every cycle plus directed timing pins
module tb_saa_tone_bank;
    localparam int CH = 6;
    localparam int FW = 8;
    localparam int OW = 3;

    logic          clk_sys = 0, rst_n = 0, ce = 0, sync = 0, wr = 0;
    logic [2:0]    wr_ch = 0;
    logic [FW-1:0] wr_freq = 0;
    logic [OW-1:0] wr_oct = 0;
    logic [CH-1:0] tone, pulse;
    logic          busy, overrun;

    int n_tests = 0, n_fail = 0, n_ce = 0;
    int tq0[$], tq1[$];

    int            rem [CH];
    int            stf [CH];
    int            sto [CH];
    int            left, m_ch;
    logic [CH-1:0] m_tone, m_pulse;
    logic          m_ov;

    saa_tone_bank #(.CHANNELS(CH), .FREQ_W(FW), .OCT_W(OW)) dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .ce(ce), .sync(sync), .wr(wr),
        .wr_ch(wr_ch), .wr_freq(wr_freq), .wr_oct(wr_oct),
        .tone(tone), .pulse(pulse), .busy(busy), .overrun(overrun)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic int per(int f, int o);
        return ((2 ** (FW + 1) - 1 - f) << (2 ** OW - o)) - 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // rem = accepted ticks left until the channel toggles
    always @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) begin
                rem[c] = per(0, 0) + 1;
                stf[c] = 0;
                sto[c] = 0;
            end
            left = 0;
            m_tone = '0;
            m_pulse = '0;
            m_ov = 0;
        end else begin
            if (ce && left > 0) m_ov = 1;
            if (wr && wr_ch < CH) begin
                stf[wr_ch] = wr_freq;
                sto[wr_ch] = wr_oct;
            end
            m_pulse = '0;
            if (sync) begin
                for (int c = 0; c < CH; c++) rem[c] = per(stf[c], sto[c]) + 1;
                m_tone = '0;
                left = 0;
            end else if (left > 0) begin
                m_ch = CH - left;
                rem[m_ch]--;
                if (rem[m_ch] == 0) begin
                    m_tone[m_ch] = ~m_tone[m_ch];
                    m_pulse[m_ch] = 1;
                    rem[m_ch] = per(stf[m_ch], sto[m_ch]) + 1;
                end
                left--;
            end else if (ce)
                left = CH;
        end
    end

    always @(negedge clk_sys)
        if (rst_n) chk("cycle", 32'({tone, pulse, busy, overrun}), 32'({m_tone, m_pulse, left > 0, m_ov}));

    always @(negedge clk_sys)
        if (rst_n) begin
            if (pulse[0]) tq0.push_back(n_ce);
            if (pulse[1]) tq1.push_back(n_ce);
        end

    task automatic tick();
        @(negedge clk_sys);
    endtask

    task automatic wr_cfg(input int ch, input int f, input int o);
        wr = 1;
        wr_ch = 3'(ch);
        wr_freq = FW'(f);
        wr_oct = OW'(o);
        tick();
        wr = 0;
    endtask

    task automatic run_ce(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            ce = 1;
            n_ce++;
            tick();
            ce = 0;
            repeat (gap - 1) tick();
        end
    endtask

    task automatic restart_count();
        n_ce = 0;
        tq0.delete();
        tq1.delete();
    endtask

    initial begin
        repeat (3) tick();
        chk("model_per_0_0", 32'(per(0, 0)), 130815);
        chk("model_per_255_7", 32'(per(255, 7)), 511);
        chk("reset_outputs", 32'({tone, pulse, busy, overrun}), 0);
        rst_n = 1;
        tick();
        wr_cfg(0, 255, 7);
        wr_cfg(1, 255, 6);
        wr_cfg(CH, 0, 0);
        sync = 1;
        repeat (3) tick();
        sync = 0;
        restart_count();
        run_ce(600, 7);
        wr_cfg(1, 255, 7);
        run_ce(940, 7);
        chk("ch0_toggle_count", 32'(tq0.size()), 3);
        chk("ch0_toggle_1", 32'(tq0.size() > 0 ? tq0[0] : -1), 512);
        chk("ch0_toggle_2", 32'(tq0.size() > 1 ? tq0[1] : -1), 1024);
        chk("ch0_toggle_3", 32'(tq0.size() > 2 ? tq0[2] : -1), 1536);
        chk("ch1_toggle_count", 32'(tq1.size()), 2);
        chk("ch1_old_period", 32'(tq1.size() > 0 ? tq1[0] : -1), 1024);
        chk("ch1_new_period", 32'(tq1.size() > 1 ? tq1[1] : -1), 1536);
        chk("default_channels_low", 32'(tone[5:2]), 0);
        ce = 1;
        tick();
        ce = 0;
        tick();
        chk("busy_before_sync", 32'(busy), 1);
        sync = 1;
        repeat (20) tick();
        chk("sync_tone_low", 32'(tone), 0);
        chk("sync_not_busy", 32'(busy), 0);
        sync = 0;
        restart_count();
        run_ce(515, 7);
        chk("sync_restart_ch0", 32'(tq0.size() > 0 ? tq0[0] : -1), 512);
        chk("sync_restart_ch1", 32'(tq1.size() > 0 ? tq1[0] : -1), 512);
        run_ce(1, 3);
        chk("overrun_after_1st", 32'(overrun), 0);
        run_ce(1, 3);
        chk("overrun_after_2nd", 32'(overrun), 1);
        run_ce(10, 3);
        chk("overrun_sticky", 32'(overrun), 1);
        repeat (8) tick();
        ce = 1;
        tick();
        ce = 0;
        tick();
        chk("pre_reset_state", 32'({tone[1:0], busy}), 32'b111);
        #2 rst_n = 0;
        #1 chk("async_reset", 32'({tone, pulse, busy, overrun}), 0);
        tick();
        rst_n = 1;
        wr_cfg(CH, 255, 7);
        run_ce(20, 7);
        chk("ignored_write_no_toggle", 32'(tone), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
